// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its prefetch queue.
package ifetch_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] PC_MASK    = ~(32'(INST_BYTES) - 32'd1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & PC_MASK;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: DEPTH-entry circular FIFO of {pc, inst} with flush, allowing push and pop in one cycle when full.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: boot/run/halt FSM, fetch PC and redirect handling over a prefetch queue.
// Optional stall counter port enabled by defining IFETCH_STALL_CNT_EN.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             fetch_en;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     q_in;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_BOOT;
    else     state_q <= state_d;
  end

  // Redirect leaves the state alone; only halt moves between RUN and HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (halt)  state_d = S_HALT;
      S_HALT:  if (!halt) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    halted   = (state_q == S_HALT);
    fetch_en = (state_q == S_RUN) && !halt && !redirect_valid;
  end

  assign out_valid = (q_count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = fetch_en && (!q_full || pop);
  assign q_in      = '{pc: fetch_pc_q, inst: imem_inst};
  assign imem_a    = fetch_pc_q;
  assign out_inst  = q_empty ? '0 : q_head.inst;
  assign out_pc    = q_empty ? '0 : q_head.pc;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = pc_align(redirect_pc);
    else if (push)      fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= pc_align(RESET_PC);
    else     fetch_pc_q <= fetch_pc_d;
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (q_in),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where decode holds off a valid head.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
